alarm_time_counter: RTL and testbench
=====================================

Name: alarm_time_counter

Overview:
- Keeps the running 24-hour time of day as four BCD digits: HH:MM.
- Feeds the current_time_* digit inputs of the four-digit display/alarm-compare stage directly downstream.
- Advances by one minute on each one_minute strobe from the timebase.
- Accepts a parallel load of a new time keyed in by the user; the controller asserts the load.

Parameters:
- RST_HR, 8'h00, BCD hour value loaded on reset; {ms_hr, ls_hr}; must be a legal 00-23.
- RST_MIN, 8'h00, BCD minute value loaded on reset; {ms_min, ls_min}; must be a legal 00-59.

Ports:
- clock  input  1  Single system clock; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-low reset; low forces the reset state immediately.
- one_minute  input  1  Single-cycle strobe; advances time by one minute.
- load_new_c  input  1  Single-cycle strobe; loads new_current_time_* digits.
- new_current_time_ms_hr  input  4  BCD tens of hours to load.
- new_current_time_ls_hr  input  4  BCD units of hours to load.
- new_current_time_ms_min  input  4  BCD tens of minutes to load.
- new_current_time_ls_min  input  4  BCD units of minutes to load.
- current_time_ms_hr  output  4  BCD tens of hours, registered.
- current_time_ls_hr  output  4  BCD units of hours, registered.
- current_time_ms_min  output  4  BCD tens of minutes, registered.
- current_time_ls_min  output  4  BCD units of minutes, registered.
- day_wrap  output  1  One-cycle registered pulse on the 23:59 -> 00:00 transition.
- load_err  output  1  One-cycle registered pulse on a rejected load; only live when LOAD_CHECK_EN is defined.

Behaviour:
- Reset (reset low, asynchronous):
  - Digits take RST_HR/RST_MIN.
  - day_wrap = 0, load_err = 0.
- Reset release is synchronous to clock. The first edge with reset high evaluates strobes normally.
- All outputs are registered. A strobe sampled at edge N is visible after edge N, which is 1-cycle latency. No combinational path runs from inputs to outputs.
- Priority each edge: load_new_c > one_minute > hold.
  - When both strobes are high in the same cycle, the load wins and the minute strobe is dropped. It is not deferred.
- Load: all four digits are replaced simultaneously from new_current_time_*. day_wrap = 0 that cycle.
- Increment on one_minute, BCD per digit:
  - ls_min < 9: ls_min + 1.
  - ls_min = 9: ls_min = 0, ms_min + 1.
  - ms_min = 5 and ls_min = 9: minutes = 00, hour increments.
  - Hour increment, ls_hr < 9 and not 23: ls_hr + 1.
  - Hour increment, ls_hr = 9: ls_hr = 0, ms_hr + 1 (09 -> 10, 19 -> 20).
  - Hour increment at 23: hours = 00 and day_wrap = 1 for that one cycle.
- Illegal held value: any digit out of range (possible only via an unchecked load), i.e. ms_hr > 2, hour > 23, ms_min > 5, or any digit > 9.
  - The next one_minute forces 00:00.
  - day_wrap stays 0 on this transition.
- Strobes are level-sampled per cycle. A strobe held high for k cycles is treated as k events; producing true single-cycle strobes is the upstream's responsibility.
- day_wrap and load_err are 0 in every cycle not named above.

Optional Feature:
- Macro: LOAD_CHECK_EN.
- Defined:
  - load_new_c is accepted only if the new value is a legal 24-hour BCD time: hours 00-23, minutes 00-59, every digit <= 9.
  - Illegal load: digits hold their previous value and load_err = 1 for one cycle.
  - A simultaneous one_minute in a rejected-load cycle is still dropped.
- Not defined:
  - Loads are taken verbatim with no checking.
  - load_err is tied to 0.
  - Illegal values are recovered by the increment rule above.

Test Plan:
- Reset, then release with defaults -> outputs 0,0,0,0; day_wrap = 0. Assert reset mid-count at 12:34 -> outputs return to 00:00 before the next clock edge.
- Load 1,9,5,9, then one one_minute -> 20:00 after 1 cycle. Load 0,9,5,9 + one_minute -> 10:00.
- Load 2,3,5,9, then one_minute -> 00:00; day_wrap high exactly 1 cycle, then low.
- Load 0,7,3,0 with one_minute high in the same cycle -> 07:30 (minute dropped). Next one_minute -> 07:31.
- Hold 11:11 with no strobes for 100 cycles -> outputs unchanged; day_wrap and load_err stay 0.
- LOAD_CHECK_EN defined, at 05:05: load 2,4,0,0 -> holds 05:05, load_err = 1 one cycle. Load 1,2,6,0 -> same. Undefined, load 2,4,0,0 then one_minute -> 00:00 with day_wrap = 0.

Source files
------------

// File: rtl/alarm_time_counter.sv
// alarm_time_counter
// Running 24-hour HH:MM time of day held as four BCD digits. Advances one
// minute per one_minute strobe and accepts a parallel load of a new time.
// A load takes priority over a minute strobe in the same cycle; the minute
// strobe is then dropped, not deferred.
// Optional feature macro: LOAD_CHECK_EN. When it is defined, a load of an
// illegal time is rejected, the digits hold, and load_err pulses. When it is
// not defined, loads are taken verbatim and load_err is tied low.
module alarm_time_counter #(
   parameter logic [7:0] RST_HR  = 8'h00,
   parameter logic [7:0] RST_MIN = 8'h00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_minute,
   input  logic       load_new_c,
   input  logic [3:0] new_current_time_ms_hr,
   input  logic [3:0] new_current_time_ls_hr,
   input  logic [3:0] new_current_time_ms_min,
   input  logic [3:0] new_current_time_ls_min,
   output logic [3:0] current_time_ms_hr,
   output logic [3:0] current_time_ls_hr,
   output logic [3:0] current_time_ms_min,
   output logic [3:0] current_time_ls_min,
   output logic       day_wrap,
   output logic       load_err
);

   logic [3:0] ms_hr_reg, ls_hr_reg, ms_min_reg, ls_min_reg;
   logic [3:0] ms_hr_next, ls_hr_next, ms_min_next, ls_min_next;
   logic       day_wrap_reg, day_wrap_next;
   logic       load_err_reg, load_err_next;
   logic       cur_legal;

   // A time is legal when every digit is a BCD digit, hours <= 23 and
   // minutes <= 59.
   function automatic logic is_legal(input logic [3:0] mh, input logic [3:0] lh,
                                     input logic [3:0] mm, input logic [3:0] lm);
      return (mh <= 4'd2) && (lh <= 4'd9) && (mm <= 4'd5) && (lm <= 4'd9) &&
             !((mh == 4'd2) && (lh > 4'd3));
   endfunction

   assign cur_legal = is_legal(ms_hr_reg, ls_hr_reg, ms_min_reg, ls_min_reg);

`ifdef LOAD_CHECK_EN
   logic new_legal;
   assign new_legal = is_legal(new_current_time_ms_hr, new_current_time_ls_hr,
                               new_current_time_ms_min, new_current_time_ls_min);
`endif

   // Next-state logic: load beats minute increment beats hold.
   always_comb begin
      ms_hr_next    = ms_hr_reg;
      ls_hr_next    = ls_hr_reg;
      ms_min_next   = ms_min_reg;
      ls_min_next   = ls_min_reg;
      day_wrap_next = 1'b0;
      load_err_next = 1'b0;
      if (load_new_c) begin
`ifdef LOAD_CHECK_EN
         if (new_legal) begin
            ms_hr_next  = new_current_time_ms_hr;
            ls_hr_next  = new_current_time_ls_hr;
            ms_min_next = new_current_time_ms_min;
            ls_min_next = new_current_time_ls_min;
         end else begin
            load_err_next = 1'b1;
         end
`else
         ms_hr_next  = new_current_time_ms_hr;
         ls_hr_next  = new_current_time_ls_hr;
         ms_min_next = new_current_time_ms_min;
         ls_min_next = new_current_time_ls_min;
`endif
      end else if (one_minute) begin
         if (!cur_legal) begin
            // Recover from an out-of-range held value without signalling a wrap.
            ms_hr_next  = 4'd0;
            ls_hr_next  = 4'd0;
            ms_min_next = 4'd0;
            ls_min_next = 4'd0;
         end else if (ls_min_reg != 4'd9) begin
            ls_min_next = ls_min_reg + 4'd1;
         end else begin
            ls_min_next = 4'd0;
            if (ms_min_reg != 4'd5) begin
               ms_min_next = ms_min_reg + 4'd1;
            end else begin
               ms_min_next = 4'd0;
               if ((ms_hr_reg == 4'd2) && (ls_hr_reg == 4'd3)) begin
                  ms_hr_next    = 4'd0;
                  ls_hr_next    = 4'd0;
                  day_wrap_next = 1'b1;
               end else if (ls_hr_reg == 4'd9) begin
                  ls_hr_next = 4'd0;
                  ms_hr_next = ms_hr_reg + 4'd1;
               end else begin
                  ls_hr_next = ls_hr_reg + 4'd1;
               end
            end
         end
      end
   end

   // State registers with asynchronous active-low reset to the reset time.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ms_hr_reg    <= RST_HR[7:4];
         ls_hr_reg    <= RST_HR[3:0];
         ms_min_reg   <= RST_MIN[7:4];
         ls_min_reg   <= RST_MIN[3:0];
         day_wrap_reg <= 1'b0;
         load_err_reg <= 1'b0;
      end else begin
         ms_hr_reg    <= ms_hr_next;
         ls_hr_reg    <= ls_hr_next;
         ms_min_reg   <= ms_min_next;
         ls_min_reg   <= ls_min_next;
         day_wrap_reg <= day_wrap_next;
         load_err_reg <= load_err_next;
      end
   end

   assign current_time_ms_hr  = ms_hr_reg;
   assign current_time_ls_hr  = ls_hr_reg;
   assign current_time_ms_min = ms_min_reg;
   assign current_time_ls_min = ls_min_reg;
   assign day_wrap            = day_wrap_reg;
   assign load_err            = load_err_reg;

endmodule

// File: tb/tb_alarm_time_counter.sv
// tb_alarm_time_counter
// Directed vector table, hold and asynchronous-reset sequences, then random
// loads/minute strobes against a minutes-of-day reference model.
// Honours LOAD_CHECK_EN the same way as the design.
module tb_alarm_time_counter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       one_minute = 1'b0;
   logic       load_new_c = 1'b0;
   logic [3:0] n_mh = 4'd0, n_lh = 4'd0, n_mm = 4'd0, n_lm = 4'd0;
   logic [3:0] c_mh, c_lh, c_mm, c_lm;
   logic       day_wrap, load_err;

   int total = 0;
   int bad   = 0;

`ifdef LOAD_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   alarm_time_counter dut (
      .clock                   (clock),
      .reset                   (reset),
      .one_minute              (one_minute),
      .load_new_c              (load_new_c),
      .new_current_time_ms_hr  (n_mh),
      .new_current_time_ls_hr  (n_lh),
      .new_current_time_ms_min (n_mm),
      .new_current_time_ls_min (n_lm),
      .current_time_ms_hr      (c_mh),
      .current_time_ls_hr      (c_lh),
      .current_time_ms_min     (c_mm),
      .current_time_ls_min     (c_lm),
      .day_wrap                (day_wrap),
      .load_err                (load_err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        ld;
      logic        mn;
      logic [15:0] nd;
      logic [15:0] ed;
      logic        edw;
      logic        ele;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic ld, input logic mn, input logic [15:0] nd,
                               input logic [15:0] ed, input logic edw, input logic ele);
      vec_t v;
      v.ld = ld; v.mn = mn; v.nd = nd; v.ed = ed; v.edw = edw; v.ele = ele;
      return v;
   endfunction

   function automatic logic [17:0] outs();
      return {c_mh, c_lh, c_mm, c_lm, day_wrap, load_err};
   endfunction

   task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got time=%h dw=%b le=%b, want time=%h dw=%b le=%b",
                  nm, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
      end
   endtask

   // Drive one cycle of inputs, let the rising edge take them, sample 1 after.
   task automatic apply(input logic ld, input logic mn, input logic [15:0] nd);
      load_new_c = ld;
      one_minute = mn;
      {n_mh, n_lh, n_mm, n_lm} = nd;
      @(posedge clock);
      #1;
      load_new_c = 1'b0;
      one_minute = 1'b0;
   endtask

   // Reference model: time as integer minutes of the day.
   int md[4];
   logic m_dw, m_le;

   function automatic bit legal4(input int a, input int b, input int c, input int d);
      return a <= 9 && b <= 9 && c <= 9 && d <= 9 && (a * 10 + b) <= 23 && (c * 10 + d) <= 59;
   endfunction

   task automatic model_step(input logic ld, input logic mn, input logic [15:0] nd);
      int t;
      m_dw = 1'b0;
      m_le = 1'b0;
      if (ld) begin
         if (CHK && !legal4(int'(nd[15:12]), int'(nd[11:8]), int'(nd[7:4]), int'(nd[3:0])))
            m_le = 1'b1;
         else begin
            md[0] = int'(nd[15:12]); md[1] = int'(nd[11:8]);
            md[2] = int'(nd[7:4]);   md[3] = int'(nd[3:0]);
         end
      end else if (mn) begin
         if (!legal4(md[0], md[1], md[2], md[3])) t = 0;
         else begin
            t = (md[0] * 10 + md[1]) * 60 + md[2] * 10 + md[3] + 1;
            if (t == 1440) begin
               t = 0;
               m_dw = 1'b1;
            end
         end
         md[0] = (t / 60) / 10; md[1] = (t / 60) % 10;
         md[2] = (t % 60) / 10; md[3] = (t % 60) % 10;
      end
   endtask

   function automatic logic [17:0] model_outs();
      return {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3]), m_dw, m_le};
   endfunction

   initial begin
      logic [31:0] rnd;
      logic [15:0] nd;
      logic        ld, mn;
      int          h, m;

      vecs[0]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0);
      vecs[1]  = mk(1, 0, 16'h1959, 16'h1959, 0, 0);
      vecs[2]  = mk(0, 1, 16'h0000, 16'h2000, 0, 0);
      vecs[3]  = mk(1, 0, 16'h0959, 16'h0959, 0, 0);
      vecs[4]  = mk(0, 1, 16'h0000, 16'h1000, 0, 0);
      vecs[5]  = mk(1, 0, 16'h2359, 16'h2359, 0, 0);
      vecs[6]  = mk(0, 1, 16'h0000, 16'h0000, 1, 0);
      vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0);
      vecs[8]  = mk(1, 1, 16'h0730, 16'h0730, 0, 0);
      vecs[9]  = mk(0, 1, 16'h0000, 16'h0731, 0, 0);
      vecs[10] = mk(1, 0, 16'h0059, 16'h0059, 0, 0);
      vecs[11] = mk(0, 1, 16'h0000, 16'h0100, 0, 0);
      vecs[12] = mk(1, 0, 16'h1909, 16'h1909, 0, 0);
      vecs[13] = mk(0, 1, 16'h0000, 16'h1910, 0, 0);
      vecs[14] = mk(1, 0, 16'h0505, 16'h0505, 0, 0);
      vecs[15] = mk(1, 0, 16'h2400, CHK ? 16'h0505 : 16'h2400, 0, CHK);
      vecs[16] = mk(0, 0, 16'h0000, CHK ? 16'h0505 : 16'h2400, 0, 0);
      vecs[17] = mk(1, 0, 16'h1260, CHK ? 16'h0505 : 16'h1260, 0, CHK);
      vecs[18] = mk(0, 1, 16'h0000, CHK ? 16'h0506 : 16'h0000, 0, 0);
      vecs[19] = mk(1, 1, 16'h2400, CHK ? 16'h0506 : 16'h2400, 0, CHK);
      vecs[20] = mk(0, 1, 16'h0000, CHK ? 16'h0507 : 16'h0000, 0, 0);
      vecs[21] = mk(1, 0, 16'h1A00, CHK ? 16'h0507 : 16'h1A00, 0, CHK);
      vecs[22] = mk(0, 1, 16'h0000, CHK ? 16'h0508 : 16'h0000, 0, 0);

      // Reset state, then release between edges.
      #12;
      check("reset_state", outs(), 18'h0);
      reset = 1'b1;
      #1;

      for (int i = 0; i < NV; i++) begin
         apply(vecs[i].ld, vecs[i].mn, vecs[i].nd);
         check($sformatf("vec%0d", i), outs(), {vecs[i].ed, vecs[i].edw, vecs[i].ele});
         $display("vec%0d ld=%b mn=%b nd=%h -> %h%h:%h%h dw=%b le=%b", i, vecs[i].ld,
                  vecs[i].mn, vecs[i].nd, c_mh, c_lh, c_mm, c_lm, day_wrap, load_err);
      end

      // Hold 11:11 with no strobes.
      apply(1, 0, 16'h1111);
      check("hold_load", outs(), {16'h1111, 2'b00});
      for (int i = 0; i < 100; i++) begin
         apply(0, 0, 16'h0000);
         check($sformatf("hold%0d", i), outs(), {16'h1111, 2'b00});
      end

      // Asynchronous reset mid-count at 12:34, seen before the next edge.
      apply(1, 0, 16'h1233);
      apply(0, 1, 16'h0000);
      check("pre_reset", outs(), {16'h1234, 2'b00});
      #1 reset = 1'b0;
      #1 check("async_reset", outs(), 18'h0);
      #1 reset = 1'b1;

      // Random traffic against the reference model, starting at 00:00.
      md = '{0, 0, 0, 0};
      for (int i = 0; i < 400; i++) begin
         rnd = $urandom;
         ld = (rnd[3:0] < 4'd3);
         mn = rnd[4];
         if (rnd[5]) begin
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            nd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
         end else begin
            nd = rnd[31:16];
         end
         if (rnd[9:6] == 4'd0) begin
            ld = 1'b1;
            nd = 16'h2359;
         end
         model_step(ld, mn, nd);
         apply(ld, mn, nd);
         check($sformatf("rand%0d", i), outs(), model_outs());
         $display("rand%0d ld=%b mn=%b nd=%h -> %h%h:%h%h dw=%b le=%b", i, ld, mn, nd,
                  c_mh, c_lh, c_mm, c_lm, day_wrap, load_err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
